fg_config_sequencer: RTL
========================

# fg_config_sequencer

Configuration controller for the function generator. It assembles the 64-bit configuration word from byte-wide host writes into a shadow register. On request it commits that word atomically to the active `CR_bus_o` that drives the generator, and sequences the generator's output enable around the update. Commits are deferred to a waveform-period boundary, or forced by timeout, so a running output never sees a half-updated configuration. Commits that change mode bits are additionally muted.

## Interface
- `CONFIG_REG_BITWIDTH`, 64: width of the configuration word. Fixed at 8 bytes.
- `MUTE_CYCLES`, 16: number of cycles the output is held disabled around a mode-changing commit. Must be ≥ 1.
- `SYNC_TIMEOUT`, 1023: maximum number of cycles spent waiting for `boundary_i` before a forced commit. Must be ≥ 1.
- `RESET_CR`, 64'h0: reset value of the shadow and active registers.
- `clk_i` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `wr_valid_i` in 1: byte-write strobe.
- `wr_addr_i` in 3: byte index. 0 selects bits [7:0]; 7 selects bits [63:56].
- `wr_data_i` in 8: write data.
- `wr_ready_o` out 1: writes are accepted (high only in IDLE).
- `commit_i` in 1: single-cycle commit request.
- `enable_i` in 1: host output-enable request.
- `boundary_i` in 1: period-boundary pulse from the generator timer.
- `CR_bus_o` out 64: active configuration word driven to the generator.
- `outputEnable_o` out 1: enable driven to the generator (registered).
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse, coincident with the first cycle the new `CR_bus_o` is valid.
- `commit_err_o` out 1: one-cycle pulse when `commit_i` arrives while busy.

## Operation
- **Shadow register.** A write is performed when `wr_valid_i && wr_ready_o`; it loads byte `wr_addr_i` of the shadow register. Writes while busy are dropped and leave the shadow unchanged.
- **Mode bits.** Bits [63:61] of the word (constant / modulated / radix).
- **IDLE.**
  - `commit_i` with `outputEnable_o` = 0 goes to APPLY.
  - Otherwise, if shadow[63:61] ≠ active[63:61], go to MUTE.
  - Otherwise go to WAIT_SYNC and clear the timeout counter.
- **WAIT_SYNC.**
  - Go to APPLY on `boundary_i`, or when the timeout counter reaches `SYNC_TIMEOUT`-1.
  - The counter increments every cycle in this state.
- **MUTE.**
  - `outputEnable_o` is forced to 0.
  - The counter counts `MUTE_CYCLES` cycles, then the state goes to APPLY.
- **APPLY.** Active ← shadow, `done_o` is set, then the state returns to IDLE.
- **Output enable.** `outputEnable_o` is the registered value of `enable_i && !(next state is MUTE or APPLY-after-MUTE)`. It re-enables in the cycle after the new word becomes active.
- **Same-cycle write and commit** in IDLE: the written byte is included in the committed word.
- **`commit_i` while busy:** ignored; `commit_err_o` pulses; the in-flight commit continues unchanged.
- **`enable_i` falling during WAIT_SYNC:** the commit still waits for a boundary or the timeout. The APPLY decision is made only in IDLE.
- **Reset mid-operation:**
  - State returns to IDLE.
  - Shadow and active return to `RESET_CR`.
  - All pulse outputs go to 0 and `outputEnable_o` goes to 0.
  - No partial commit survives.

## Timing
- **Reset values:**
  - `CR_bus_o` = `RESET_CR`.
  - `outputEnable_o`, `busy_o`, `done_o`, `commit_err_o` = 0.
  - `wr_ready_o` = 1.
- **Write latency.** A write in cycle t is visible in the shadow at t+1.
- **Immediate commit** (output disabled):
  - `commit_i` in cycle t: APPLY in t+1.
  - `CR_bus_o` updated and `done_o` high in t+2.
  - `busy_o` high in t+1 only.
- **Synced commit:**
  - `commit_i` in cycle t; `boundary_i` in cycle b ≥ t+1.
  - APPLY in b+1; new `CR_bus_o` and `done_o` in b+2.
  - A `boundary_i` in cycle t itself is ignored.
- **Timeout.** With no boundary, APPLY occurs in t+1+`SYNC_TIMEOUT` and `done_o` pulses one cycle later.
- **Muted commit:**
  - `outputEnable_o` is 0 from t+1.
  - APPLY in t+1+`MUTE_CYCLES`; `done_o` one cycle later.
  - `outputEnable_o` returns to `enable_i` in the cycle after `done_o`.
- **Throughput.** At most one commit in flight. `wr_ready_o` rises in the same cycle as `done_o`.

## Test plan
- **Reset and byte writes.** Reset, then write bytes 0..7 with values 0x11..0x88 and commit with `enable_i` = 0. Expect `CR_bus_o` = 64'h8877665544332211 two cycles after `commit_i`, a single `done_o` pulse, and `outputEnable_o` = 0 throughout.
- **Synced commit.** Set `enable_i` = 1 with active mode bits = 3'b010, write byte 1 = 0x7F, commit, and pulse `boundary_i` 5 cycles later. Expect `CR_bus_o`[15:8] = 0x7F exactly 2 cycles after `boundary_i`, `outputEnable_o` high throughout, and a write attempted while busy dropped.
- **Timeout.** With `SYNC_TIMEOUT` = 8 and no boundary: `commit_i` at t gives `done_o` at t+10.
- **Mode-change mute.** Flip bit 63 in the shadow and commit with `MUTE_CYCLES` = 4. Expect `outputEnable_o` = 0 for cycles t+1 through t+6, `done_o` at t+6, and `outputEnable_o` = 1 at t+7.
- **Error and same-cycle cases:**
  - `commit_i` during WAIT_SYNC: `commit_err_o` pulses once and the original commit completes.
  - Write byte 0 = 0xAA in the same cycle as `commit_i`: committed word[7:0] = 0xAA.
- **Reset mid-operation.** Assert `rst_n` = 0 during MUTE. Expect IDLE, `CR_bus_o` = `RESET_CR`, and no `done_o` pulse.

Source files
------------

// File: rtl/fg_config_sequencer_if.sv
// Host-side bus of the function-generator configuration sequencer: byte writes,
// commit handshake, sync pulse and the active configuration word.
interface fg_config_sequencer_if #(
  parameter int unsigned CONFIG_REG_BITWIDTH = 64
);
  logic                           wr_valid_i;
  logic [2:0]                     wr_addr_i;
  logic [7:0]                     wr_data_i;
  logic                           wr_ready_o;
  logic                           commit_i;
  logic                           enable_i;
  logic                           boundary_i;
  logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o;
  logic                           outputEnable_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           commit_err_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, commit_i, enable_i, boundary_i,
    input  wr_ready_o, CR_bus_o, outputEnable_o, busy_o, done_o, commit_err_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, commit_i, enable_i, boundary_i,
    output wr_ready_o, CR_bus_o, outputEnable_o, busy_o, done_o, commit_err_o
  );
endinterface

// File: rtl/fg_config_sequencer.sv
// Shadow/active configuration register for the function generator; commits are
// deferred to a period boundary (or timeout) and muted when the mode bits change.
module fg_config_sequencer #(
  parameter int unsigned                   CONFIG_REG_BITWIDTH = 64,
  parameter int unsigned                   MUTE_CYCLES         = 16,
  parameter int unsigned                   SYNC_TIMEOUT        = 1023,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CR           = '0
) (
  input logic                    clk_i,
  input logic                    rst_n,
  fg_config_sequencer_if.slave   bus
);
  localparam int unsigned CntMax = (MUTE_CYCLES > SYNC_TIMEOUT) ? MUTE_CYCLES : SYNC_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SyncLast = CntW'(SYNC_TIMEOUT - 1);
  localparam logic [CntW-1:0] MuteLast = CntW'(MUTE_CYCLES - 1);
  localparam int unsigned ModeTop = CONFIG_REG_BITWIDTH - 1;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaitSync = 2'd1;
  localparam logic [1:0] StMute     = 2'd2;
  localparam logic [1:0] StApply    = 2'd3;

  logic [1:0]                     state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [CONFIG_REG_BITWIDTH-1:0] shadow_q, shadow_d;
  logic [CONFIG_REG_BITWIDTH-1:0] active_q, active_d;
  logic                           muted_q, muted_d;
  logic                           oe_q, oe_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic                           idle;
  logic                           wr_en;

  assign idle  = (state_q == StIdle);
  assign wr_en = bus.wr_valid_i && idle;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[{bus.wr_addr_i, 3'b000} +: 8] = bus.wr_data_i;
    end
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    muted_d  = muted_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = bus.commit_i && !idle;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.commit_i) begin
          // Post-write shadow is used so a same-cycle byte write joins the commit.
          if (!oe_q) begin
            state_d = StApply;
          end else if (shadow_d[ModeTop -: 3] != active_q[ModeTop -: 3]) begin
            state_d = StMute;
            muted_d = 1'b1;
          end else begin
            state_d = StWaitSync;
          end
        end
      end
      StWaitSync: begin
        if (bus.boundary_i || (cnt_q == SyncLast)) state_d = StApply;
      end
      StMute: begin
        if (cnt_q == MuteLast) state_d = StApply;
      end
      StApply: begin
        active_d = shadow_q;
        done_d   = 1'b1;
        muted_d  = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Output stays off from mute entry until the cycle after the new word is active.
    oe_d = bus.enable_i && !((state_d == StMute) || muted_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= RESET_CR;
      active_q <= RESET_CR;
      muted_q  <= 1'b0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      muted_q  <= muted_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.wr_ready_o     = idle;
  assign bus.busy_o         = !idle;
  assign bus.CR_bus_o       = active_q;
  assign bus.outputEnable_o = oe_q;
  assign bus.done_o         = done_q;
  assign bus.commit_err_o   = err_q;
endmodule
